can_frame_receiver: RTL
=======================

// Module: can_frame_receiver
// PURPOSE
//  Serial-to-frame receive end of the CAN transfer layer. Samples the rx bit once per baud tick.
//  Removes stuff bits, checks the frame (CRC-15, form, stuff) and assembles a standard CAN 2.0A frame into rx_message.
//  Reports each good frame with a one-cycle RXOK pulse to the object layer.
//  Mirror of the transmitter that drives tx; the two are joined by the rx=tx loopback at top level.
// PARAMETERS
//  STUFF_LIMIT  5   equal consecutive bits before a stuff bit is expected
//  EOF_BITS     7   recessive end-of-frame bits
//  IDLE_BITS    11  consecutive recessive bits required for bus-idle before SOF is accepted
// PORTS
//  sys_clk       in   1    system clock, all logic on rising edge
//  IP2Can_reset  in   1    synchronous, active-high reset
//  baud_tick     in   1    one-sys_clk-cycle strobe, bit sample point; logic advances only when high
//  rx            in   1    serial CAN bit, 0=dominant, 1=recessive
//  rx_message    out  128  [127:117] ID, [116] RTR, [115:112] DLC, [111:48] data (byte0 at [111:104]), [47:0] zero
//  RXOK          out  1    one-cycle pulse: rx_message holds a new valid frame
//  rx_error      out  1    one-cycle pulse: frame aborted
//  rx_err_code   out  3    1=stuff, 2=CRC, 3=form, 4=IDE=1 (unsupported); held until next error
//  rx_busy       out  1    high from SOF until frame end or abort
//  ack_drive     out  1    see CONFIGURATION
// BEHAVIOUR
//  Reset: all outputs 0, state=IDLE, idle count=0.
//  Reset mid-frame: partial frame is discarded and no pulse is raised.
//  States, advancing on baud_tick only:
//   IDLE -> SOF_WAIT after IDLE_BITS consecutive 1s; any 0 restarts the count.
//   SOF_WAIT -> ARB on rx=0.
//   ARB: 11 ID bits (MSB first) + RTR, then CTRL.
//   CTRL: IDE, r0, DLC[3:0]. IDE=1 raises error code 4.
//   DATA: min(DLC,8)*8 bits. Skipped when RTR=1 or DLC=0. DLC>8 is stored raw; 8 bytes are read.
//   CRC: 15 bits.
//   CRC_DEL, ACK_SLOT, ACK_DEL, EOF: rx_busy stays high through all of these.
//   ERROR -> IDLE.
//  Destuffing:
//   Applies from SOF through the last CRC bit.
//   After STUFF_LIMIT equal bits, the next bit must be the complement. It is discarded and restarts the run at 1.
//   A stuff bit equal to the run raises error code 1.
//   The stuff bit after the last CRC bit is still consumed.
//  CRC:
//   Polynomial 0x4599, 15-bit register init 0, over destuffed SOF..last data bit.
//   Compared at the last CRC bit; a mismatch raises error code 2 at CRC_DEL entry.
//  Form checks:
//   CRC_DEL, ACK_DEL and every EOF bit must be 1, else error code 3.
//   ACK_SLOT accepts either value.
//  Success:
//   On the baud_tick of the last EOF bit, rx_message is loaded and RXOK=1 for that one sys_clk cycle.
//   rx_message holds until the next good frame. Unused data bytes are 0.
//  Error:
//   rx_error=1 for one cycle and rx_err_code is updated. rx_busy drops and rx_message is unchanged.
//   The block re-enters IDLE, needing IDLE_BITS recessive bits.
//  baud_tick=0: no state, counter or CRC change.
//  Latency: RXOK follows the sys_clk edge at the final EOF sample, a registered output with no extra delay.
// CONFIGURATION
//  CAN_RX_ACK_DRIVE_EN defined:
//   ack_drive=1 throughout the ACK_SLOT bit when the CRC matched, so top level can force a dominant ACK.
//  CAN_RX_ACK_DRIVE_EN undefined: ack_drive tied 0 and the ACK logic is not compiled.
// TESTING
//  Good frame: ID=0x123, RTR=0, DLC=2, data AB CD, correct CRC.
//   -> RXOK once; rx_message[127:112]=0x2462, [111:96]=0xABCD, the rest 0; rx_err_code unchanged.
//  ID=0x000, DLC=0 (long dominant runs, stuffed).
//   -> RXOK; ID=0, DLC=0; every inserted stuff bit removed.
//  Six dominant bits inside the ID field -> rx_error, rx_err_code=1, no RXOK, rx_busy=0.
//  Good frame with CRC bit 0 flipped -> rx_error, code 2; rx_message still holds the previous frame.
//  Good frame with EOF bit 4 dominant -> rx_error, code 3; a following good frame after 11 recessive bits -> RXOK.
//  Reset mid-data:
//   -> all outputs 0.
//   An SOF within 11 recessive bits is ignored.
//   A frame after 11 recessive bits -> RXOK.
//  With CAN_RX_ACK_DRIVE_EN: ack_drive=1 exactly during the ACK slot of a good frame, 0 on a CRC-fail frame.

Source files
------------

// File: rtl/can_frame_receiver.sv
// CAN 2.0A receive path: destuffing, CRC-15, form checks and frame assembly into rx_message.
// Optional dominant-ACK request output enabled by defining CAN_RX_ACK_DRIVE_EN.
module can_frame_receiver #(
    parameter int unsigned STUFF_LIMIT = 5,
    parameter int unsigned EOF_BITS    = 7,
    parameter int unsigned IDLE_BITS   = 11
) (
    input  logic         sys_clk,
    input  logic         IP2Can_reset,
    input  logic         baud_tick,
    input  logic         rx,
    output logic [127:0] rx_message,
    output logic         RXOK,
    output logic         rx_error,
    output logic [2:0]   rx_err_code,
    output logic         rx_busy,
    output logic         ack_drive
);

    typedef enum logic [3:0] {
        S_IDLE, S_SOF_WAIT, S_ARB, S_CTRL, S_DATA, S_CRC,
        S_CRC_DEL, S_ACK_SLOT, S_ACK_DEL, S_EOF, S_ERROR
    } state_t;

    localparam logic [14:0]       CRC_POLY  = 15'h4599;
    localparam int unsigned       RUN_W     = $clog2(STUFF_LIMIT + 1);
    localparam int unsigned       IDLE_W    = $clog2(IDLE_BITS + 1);
    localparam logic [RUN_W-1:0]  RUN_LIMIT = RUN_W'(STUFF_LIMIT);
    localparam logic [RUN_W-1:0]  RUN_ONE   = RUN_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_BITS - 1);
    localparam logic [6:0]        EOF_LAST  = 7'(EOF_BITS - 1);

    state_t            r_state;
    logic [IDLE_W-1:0] r_idle_cnt;
    logic [RUN_W-1:0]  r_run_cnt;
    logic              r_run_bit;
    logic [6:0]        r_bit_cnt;
    logic [6:0]        r_data_bits;
    logic [10:0]       r_id;
    logic              r_rtr;
    logic [3:0]        r_dlc;
    logic [63:0]       r_data;
    logic [14:0]       r_crc;
    logic [13:0]       r_crc_rx;

    logic              w_destuff_zone;
    logic              w_stuff_bit;
    logic [14:0]       w_crc_next;
    logic              w_crc_match;
    logic [3:0]        w_dlc_full;
    logic [3:0]        w_nbytes;
    logic              w_err;
    logic [2:0]        w_err_code;

    function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
        logic fb;
        fb = b ^ c[14];
        return {c[13:0], 1'b0} ^ (fb ? CRC_POLY : 15'd0);
    endfunction

    assign w_destuff_zone = (r_state == S_ARB) || (r_state == S_CTRL) ||
                            (r_state == S_DATA) || (r_state == S_CRC);
    // The stuff bit that may follow the last CRC bit is consumed while in CRC_DEL.
    assign w_stuff_bit = (r_run_cnt == RUN_LIMIT) && (w_destuff_zone || (r_state == S_CRC_DEL));
    assign w_crc_next  = crc_step(r_crc, rx);
    assign w_crc_match = ({r_crc_rx, rx} == r_crc);
    assign w_dlc_full  = {r_dlc[2:0], rx};
    assign w_nbytes    = w_dlc_full[3] ? 4'd8 : w_dlc_full;

    always_comb begin
        w_err      = 1'b0;
        w_err_code = 3'd0;
        if (baud_tick) begin
            if (w_stuff_bit) begin
                if (rx == r_run_bit) begin
                    w_err      = 1'b1;
                    w_err_code = 3'd1;
                end
            end else begin
                case (r_state)
                    S_CTRL: if (r_bit_cnt == 7'd0 && rx) begin
                        w_err      = 1'b1;
                        w_err_code = 3'd4;
                    end
                    S_CRC: if (r_bit_cnt == 7'd14 && !w_crc_match) begin
                        w_err      = 1'b1;
                        w_err_code = 3'd2;
                    end
                    S_CRC_DEL, S_ACK_DEL, S_EOF: if (!rx) begin
                        w_err      = 1'b1;
                        w_err_code = 3'd3;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (IP2Can_reset) begin
            r_state     <= S_IDLE;
            r_idle_cnt  <= '0;
            r_run_cnt   <= '0;
            r_run_bit   <= 1'b0;
            r_bit_cnt   <= '0;
            r_data_bits <= '0;
            r_id        <= '0;
            r_rtr       <= 1'b0;
            r_dlc       <= '0;
            r_data      <= '0;
            r_crc       <= '0;
            r_crc_rx    <= '0;
            rx_message  <= '0;
            RXOK        <= 1'b0;
            rx_error    <= 1'b0;
            rx_err_code <= '0;
            rx_busy     <= 1'b0;
        end else begin
            RXOK     <= 1'b0;
            rx_error <= 1'b0;
            if (w_err) begin
                rx_error    <= 1'b1;
                rx_err_code <= w_err_code;
                rx_busy     <= 1'b0;
                r_state     <= S_ERROR;
            end else if (baud_tick) begin
                if (w_stuff_bit) begin
                    r_run_bit <= rx;
                    r_run_cnt <= RUN_ONE;
                end else begin
                    if (w_destuff_zone) begin
                        if (rx == r_run_bit) begin
                            r_run_cnt <= r_run_cnt + 1'b1;
                        end else begin
                            r_run_bit <= rx;
                            r_run_cnt <= RUN_ONE;
                        end
                    end
                    case (r_state)
                        S_IDLE: begin
                            if (!rx) begin
                                r_idle_cnt <= '0;
                            end else if (r_idle_cnt == IDLE_LAST) begin
                                r_idle_cnt <= '0;
                                r_state    <= S_SOF_WAIT;
                            end else begin
                                r_idle_cnt <= r_idle_cnt + 1'b1;
                            end
                        end
                        S_SOF_WAIT: if (!rx) begin
                            r_state   <= S_ARB;
                            rx_busy   <= 1'b1;
                            r_run_bit <= 1'b0;
                            r_run_cnt <= RUN_ONE;
                            r_crc     <= crc_step(15'd0, 1'b0);
                            r_bit_cnt <= '0;
                            r_id      <= '0;
                            r_dlc     <= '0;
                            r_data    <= '0;
                        end
                        S_ARB: begin
                            r_crc <= w_crc_next;
                            if (r_bit_cnt == 7'd11) begin
                                r_rtr     <= rx;
                                r_bit_cnt <= '0;
                                r_state   <= S_CTRL;
                            end else begin
                                r_id      <= {r_id[9:0], rx};
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                        S_CTRL: begin
                            r_crc <= w_crc_next;
                            if (r_bit_cnt >= 7'd2) r_dlc <= w_dlc_full;
                            if (r_bit_cnt == 7'd5) begin
                                r_bit_cnt   <= '0;
                                r_data_bits <= {w_nbytes, 3'b000};
                                r_state     <= (r_rtr || w_dlc_full == 4'd0) ? S_CRC : S_DATA;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                        S_DATA: begin
                            r_crc <= w_crc_next;
                            r_data[6'd63 - r_bit_cnt[5:0]] <= rx;
                            if (r_bit_cnt == r_data_bits - 7'd1) begin
                                r_bit_cnt <= '0;
                                r_state   <= S_CRC;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                        S_CRC: begin
                            r_crc_rx <= {r_crc_rx[12:0], rx};
                            if (r_bit_cnt == 7'd14) begin
                                r_bit_cnt <= '0;
                                r_state   <= S_CRC_DEL;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                        S_CRC_DEL: r_state <= S_ACK_SLOT;
                        S_ACK_SLOT: r_state <= S_ACK_DEL;
                        S_ACK_DEL: begin
                            r_bit_cnt <= '0;
                            r_state   <= S_EOF;
                        end
                        S_EOF: begin
                            if (r_bit_cnt == EOF_LAST) begin
                                rx_message <= {r_id, r_rtr, r_dlc, r_data, 48'd0};
                                RXOK       <= 1'b1;
                                rx_busy    <= 1'b0;
                                r_idle_cnt <= '0;
                                r_state    <= S_IDLE;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                        S_ERROR: begin
                            r_idle_cnt <= rx ? IDLE_W'(1) : '0;
                            r_state    <= S_IDLE;
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

`ifdef CAN_RX_ACK_DRIVE_EN
    logic r_ack_drive;

    // CRC_DEL is only reachable after a matching CRC, so entering ACK_SLOT implies a good CRC.
    always_ff @(posedge sys_clk) begin
        if (IP2Can_reset) begin
            r_ack_drive <= 1'b0;
        end else if (w_err) begin
            r_ack_drive <= 1'b0;
        end else if (baud_tick && !w_stuff_bit) begin
            if (r_state == S_CRC_DEL) begin
                r_ack_drive <= 1'b1;
            end else if (r_state == S_ACK_SLOT) begin
                r_ack_drive <= 1'b0;
            end
        end
    end

    assign ack_drive = r_ack_drive;
`else
    assign ack_drive = 1'b0;
`endif

endmodule
